// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Pops words out of a synchronous FIFO (one-cycle read latency) and presents
// them as a valid/ready stream. A 3-entry in-order buffer absorbs the read
// latency. Reads are throttled so that words already buffered plus a read
// still in flight never exceed the buffer size. This lets fifo_r_en be
// computed without looking at m_ready.
//
// Ports:
//   clk           - single clock, rising edge
//   rst           - synchronous active-high reset
//   en            - permits new FIFO reads while high
//   fifo_empty    - FIFO empty flag
//   fifo_data_out - FIFO read data, valid the cycle after fifo_r_en
//   fifo_r_en     - FIFO pop request
//   m_valid       - stream word valid
//   m_data        - stream word (buffer head)
//   m_ready       - downstream accepts the word this cycle
//   beat_count    - number of accepted stream beats, wraps
module fifo_stream_reader #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               fifo_empty,
    input  logic [WIDTH-1:0]   fifo_data_out,
    output logic               fifo_r_en,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    input  logic               m_ready,
    output logic [COUNT_W-1:0] beat_count
);

    logic [WIDTH-1:0] entry [3];
    logic [WIDTH-1:0] entry_next [3];
    logic [1:0]       occ;
    logic [1:0]       occ_next;
    logic             pend;
    logic [2:0]       inflight;
    logic             capture;
    logic             transfer;
    logic [1:0]       slot;

    // Buffered words plus the read still in flight. This count bounds new reads,
    // so a capture always finds a free slot.
    assign inflight  = {1'b0, occ} + {2'b00, pend};
    assign fifo_r_en = !rst && en && !fifo_empty && (inflight < 3'd3);

    assign capture  = pend;
    assign m_valid  = (occ != 2'd0);
    assign m_data   = entry[0];
    assign transfer = m_valid && m_ready;

    // Next buffer contents. The head shifts forward on a transfer only when a
    // following entry exists. The last delivered word therefore stays on
    // m_data while the buffer is empty. A capture goes into the first free slot
    // after any shift.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            entry_next[i] = entry[i];
        end
        occ_next = occ;
        slot     = occ;

        if (transfer) begin
            if (occ >= 2'd2) begin
                entry_next[0] = entry[1];
            end
            if (occ == 2'd3) begin
                entry_next[1] = entry[2];
            end
            slot = occ - 2'd1;
        end

        if (capture) begin
            case (slot)
                2'd0:    entry_next[0] = fifo_data_out;
                2'd1:    entry_next[1] = fifo_data_out;
                2'd2:    entry_next[2] = fifo_data_out;
                default: entry_next[2] = entry[2];
            endcase
        end

        if (capture && !transfer) begin
            occ_next = occ + 2'd1;
        end else if (transfer && !capture) begin
            occ_next = occ - 2'd1;
        end
    end

    // State registers. Reset discards buffered words and any in-flight read.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ        <= 2'd0;
            pend       <= 1'b0;
            beat_count <= '0;
            for (int i = 0; i < 3; i++) begin
                entry[i] <= '0;
            end
        end else begin
            occ  <= occ_next;
            pend <= fifo_r_en;
            for (int i = 0; i < 3; i++) begin
                entry[i] <= entry_next[i];
            end
            if (transfer) begin
                beat_count <= beat_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//
// Drives fifo_stream_reader from a queue-based synchronous FIFO. Each cycle it
// compares the DUT against a word-level model. In that model, every word
// popped from the FIFO and not yet delivered sits in one ordered queue. A
// word becomes visible one cycle after its pop. Scenario checks against literal
// values pin down the model.
//
// Ports: none (top-level bench).
module tb_fifo_stream_reader;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               fifo_empty;
    logic [WIDTH-1:0]   fifo_data_out;
    logic               fifo_r_en;
    logic               m_valid;
    logic [WIDTH-1:0]   m_data;
    logic               m_ready;
    logic [COUNT_W-1:0] beat_count;

    fifo_stream_reader #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .fifo_empty    (fifo_empty),
        .fifo_data_out (fifo_data_out),
        .fifo_r_en     (fifo_r_en),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .beat_count    (beat_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Environment FIFO contents.
    logic [WIDTH-1:0] fifo_q [$];

    // Model: words popped but not yet delivered, in order.
    logic [WIDTH-1:0]   exp_q [$];
    bit                 read_last;
    logic [WIDTH-1:0]   hold_word;
    logic [COUNT_W-1:0] exp_beat;

    // Per-scenario statistics and a snapshot of the most recent cycle.
    int               cyc;
    int               ren_pulses;
    int               transfers;
    int               valid_cycles;
    int               first_ren_cyc;
    int               first_valid_cyc;
    logic [WIDTH-1:0] first_valid_data;
    logic             snap_valid;
    logic             snap_ren;
    logic [WIDTH-1:0] snap_data;
    logic [COUNT_W-1:0] snap_beat;
    logic [1:0]       snap_occ;
    logic             snap_pend;

    // Compares one value and reports a failure.
    task automatic checkVal(input string name, input logic [63:0] actual,
                            input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic clearStats();
        ren_pulses       = 0;
        transfers        = 0;
        valid_cycles     = 0;
        first_ren_cyc    = -1;
        first_valid_cyc  = -1;
        first_valid_data = '0;
    endtask

    // Per-cycle comparison against the model, followed by the model update.
    task automatic checkOutput(input bit rst_v, input bit en_v, input bit ready_v);
        int               size;
        int               avail;
        bit               exp_ren;
        bit               exp_valid;
        logic [WIDTH-1:0] exp_data;

        size      = exp_q.size();
        avail     = size - (read_last ? 1 : 0);
        exp_ren   = !rst_v && en_v && (fifo_q.size() != 0) && (size < 3);
        exp_valid = (avail > 0);
        exp_data  = exp_valid ? exp_q[0] : hold_word;

        checkVal("fifo_r_en", 64'(fifo_r_en), 64'(exp_ren));
        checkVal("m_valid", 64'(m_valid), 64'(exp_valid));
        checkVal("m_data", 64'(m_data), 64'(exp_data));
        checkVal("beat_count", 64'(beat_count), 64'(exp_beat));
        checkVal("capture_into_full", 64'(dut.pend && (dut.occ == 2'd3)), 64'd0);

        snap_valid = m_valid;
        snap_ren   = fifo_r_en;
        snap_data  = m_data;
        snap_beat  = beat_count;
        snap_occ   = dut.occ;
        snap_pend  = dut.pend;
        if (fifo_r_en) begin
            if (first_ren_cyc < 0) first_ren_cyc = cyc;
            ren_pulses++;
        end
        if (m_valid) begin
            if (first_valid_cyc < 0) begin
                first_valid_cyc  = cyc;
                first_valid_data = m_data;
            end
            valid_cycles++;
            if (ready_v) transfers++;
        end

        if (rst_v) begin
            exp_q.delete();
            read_last = 1'b0;
            hold_word = '0;
            exp_beat  = '0;
        end else begin
            if (exp_valid && ready_v) begin
                hold_word = exp_q.pop_front();
                exp_beat  = exp_beat + COUNT_W'(1);
            end
            if (exp_ren) begin
                exp_q.push_back(fifo_q[0]);
            end
            read_last = exp_ren;
        end
        cyc++;
    endtask

    // One clock cycle: apply inputs, check at the falling edge, then let the
    // environment FIFO pop/push at the rising edge.
    task automatic applyStimulus(input bit rst_v, input bit en_v, input bit ready_v,
                                 input bit wr_v, input logic [WIDTH-1:0] wr_data);
        bit ren_act;
        rst     = rst_v;
        en      = en_v;
        m_ready = ready_v;
        @(negedge clk);
        ren_act = fifo_r_en;
        checkOutput(rst_v, en_v, ready_v);
        @(posedge clk);
        #1;
        fifo_data_out = 32'hDEADBEEF;
        if (rst_v) begin
            fifo_q.delete();
        end else begin
            if (ren_act && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
            if (wr_v) fifo_q.push_back(wr_data);
        end
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0);
        clearStats();
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        m_ready       = 1'b0;
        fifo_empty    = 1'b1;
        fifo_data_out = '0;
        read_last     = 1'b0;
        hold_word     = '0;
        exp_beat      = '0;
        cyc           = 0;
        clearStats();
        repeat (2) @(posedge clk);
        #1;

        // Reset with an empty FIFO and en high: nothing may move.
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkVal("idle_ren_pulses", 64'(ren_pulses), 64'd0);
        checkVal("idle_valid_cycles", 64'(valid_cycles), 64'd0);
        checkVal("idle_beat", 64'(snap_beat), 64'd0);
        checkVal("idle_m_data", 64'(snap_data), 64'd0);

        // Single word: two-cycle latency from read to valid.
        resetDut();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A50001);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checkVal("single_ren_pulses", 64'(ren_pulses), 64'd1);
        checkVal("single_latency", 64'(first_valid_cyc - first_ren_cyc), 64'd2);
        checkVal("single_data", 64'(first_valid_data), 64'hA5A50001);
        checkVal("single_valid_cycles", 64'(valid_cycles), 64'd1);
        checkVal("single_beat", 64'(snap_beat), 64'd1);

        // 32 back-to-back words with the consumer always ready.
        resetDut();
        for (int i = 1; i <= 32; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, WIDTH'(i));
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checkVal("burst_transfers", 64'(transfers), 64'd32);
        checkVal("burst_valid_cycles", 64'(valid_cycles), 64'd32);
        checkVal("burst_beat", 64'(snap_beat), 64'd32);
        checkVal("burst_fifo_left", 64'(fifo_q.size()), 64'd0);

        // Backpressure: the buffer fills to 3 and the head holds.
        resetDut();
        for (int i = 1; i <= 10; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, WIDTH'(i));
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        checkVal("bp_ren_pulses", 64'(ren_pulses), 64'd3);
        checkVal("bp_occ", 64'(snap_occ), 64'd3);
        checkVal("bp_head", 64'(snap_data), 64'h1);
        checkVal("bp_fifo_left", 64'(fifo_q.size()), 64'd7);
        clearStats();
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checkVal("bp_transfers", 64'(transfers), 64'd10);
        checkVal("bp_beat", 64'(snap_beat), 64'd10);
        checkVal("bp_last_data", 64'(snap_data), 64'hA);

        // Enable gating: no reads while en=0, then exactly two.
        resetDut();
        for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, WIDTH'(32'h300 + i));
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkVal("en_off_ren_pulses", 64'(ren_pulses), 64'd0);
        clearStats();
        repeat (2) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0);
        checkVal("en_ren_pulses", 64'(ren_pulses), 64'd2);
        checkVal("en_transfers", 64'(transfers), 64'd2);
        checkVal("en_fifo_left", 64'(fifo_q.size()), 64'd3);

        // Reset mid-stream with two words buffered and one in flight.
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0);
        checkVal("pre_rst_occ", 64'(snap_occ), 64'd2);
        checkVal("pre_rst_pend", 64'(snap_pend), 64'd1);
        clearStats();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checkVal("post_rst_valid", 64'(snap_valid), 64'd0);
        checkVal("post_rst_beat", 64'(snap_beat), 64'd0);
        checkVal("post_rst_ren", 64'(snap_ren), 64'd0);
        checkVal("post_rst_data", 64'(snap_data), 64'd0);
        for (int i = 1; i <= 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, WIDTH'(32'h400 + i));
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, '0);
        checkVal("resume_transfers", 64'(transfers), 64'd3);
        checkVal("resume_beat", 64'(snap_beat), 64'd3);
        checkVal("resume_last_data", 64'(snap_data), 64'h403);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width; it matches the synchronous FIFO width.
REQ-002 SHALL have parameter COUNT_W, default 32, width of beat_count.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit; when 1, new FIFO reads are permitted.
REQ-006 SHALL have port fifo_empty, input, 1 bit; the FIFO empty flag.
REQ-007 SHALL have port fifo_data_out, input, WIDTH bits; FIFO read data, valid in the cycle after the cycle in which fifo_r_en=1.
REQ-008 SHALL have port fifo_r_en, output, 1 bit; FIFO pop request, one word per cycle when high.
REQ-009 SHALL have port m_valid, output, 1 bit; the downstream stream word is valid.
REQ-010 SHALL have port m_data, output, WIDTH bits; the downstream stream word.
REQ-011 SHALL have port m_ready, input, 1 bit; the downstream consumer accepts.
REQ-012 SHALL have port beat_count, output, COUNT_W bits; count of accepted stream beats.

Function
REQ-013 SHALL contain a 3-entry in-order output buffer with occupancy occ (0..3) and a 1-bit read-pending flag pend.
REQ-014 SHALL drive fifo_r_en = !rst && en && !fifo_empty && (occ + pend < 3).
- fifo_r_en SHALL depend only on registers, en, rst and fifo_empty.
- fifo_r_en SHALL NOT depend on m_ready.
REQ-015 SHALL set pend, on each clock edge, to the value of fifo_r_en in the preceding cycle.
REQ-016 SHALL capture fifo_data_out at the buffer tail, at the edge ending any cycle where pend=1.
REQ-017 SHALL drive m_valid = (occ > 0) and m_data = the buffer head entry.
- When occ=0, m_data SHALL hold its last value.
REQ-018 SHALL define a transfer as m_valid && m_ready in a cycle; a transfer pops the head at the clock edge.
REQ-019 SHALL, when capture and transfer occur in the same cycle, leave occ unchanged and preserve order.
REQ-020 SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-021 SHALL follow this latency: fifo_r_en high in cycle N with occ=0 -> m_valid=1 with that word in cycle N+2.
REQ-022 SHALL sustain one transfer per cycle when m_ready=1 continuously and the FIFO is non-empty.
REQ-023 SHALL never capture when occ=3; the occ+pend<3 rule guarantees this. The bench asserts it.
REQ-024 SHALL never assert fifo_r_en while fifo_empty=1.
REQ-025 SHALL, when en falls, issue no new reads, but complete a pending read into the buffer and continue draining to the consumer.
REQ-026 SHALL increment beat_count by 1 per transfer, wrapping modulo 2^COUNT_W.
REQ-027 SHALL preserve word order from the FIFO to m_data exactly, with no duplication or loss outside reset.

Reset
REQ-028 SHALL, while rst=1 at a clock edge, set occ=0, pend=0, m_valid=0, m_data=0 and beat_count=0.
- fifo_r_en SHALL be 0 throughout any cycle with rst=1.
REQ-029 SHALL, on reset mid-operation, discard buffered words and the in-flight read word.
- The FIFO is reset by the same rst source, so no stale data persists.
REQ-030 SHALL allow the first fifo_r_en no earlier than the first cycle after rst deasserts.

Verification
REQ-031 Reset, FIFO empty, en=1 -> fifo_r_en=0, m_valid=0 and beat_count=0 for 20 cycles.
REQ-032 Write single word 0xA5A50001, m_ready=1 -> fifo_r_en high exactly 1 cycle (N), m_valid=1 with m_data=0xA5A50001 in N+2 for one cycle, then beat_count=1.
REQ-033 Write 32 words 0x1..0x20 back-to-back, m_ready=1 -> 32 consecutive transfers in order after the 2-cycle latency, beat_count=32, FIFO empty at the end.
REQ-034 Hold m_ready=0, write 10 words -> exactly 3 fifo_r_en pulses, occ=3, m_data=0x1 stable, FIFO holds 7; then release m_ready=1 -> words 0x1..0xA out in order, beat_count=10.
REQ-035 en=0 with 5 words queued -> no fifo_r_en; then set en=1 for 2 cycles, then en=0 -> exactly 2 reads issued and 2 words delivered, FIFO holds 3.
REQ-036 rst=1 for 1 cycle mid-stream with occ=2 and pend=1 -> next cycle m_valid=0, beat_count=0, fifo_r_en=0; normal streaming resumes after new writes.
